// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-hot combinational grant, registered broadcast, flush kill.
// Define CDB_ARB_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module cdb_arbiter #(
    parameter int N_UNITS = 3,
    parameter int CDB_W   = 37
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [N_UNITS-1:0][CDB_W-1:0]   units_cdb,
    input  logic [N_UNITS-1:0]              units_cdb_valid,
    output logic [N_UNITS-1:0]              units_cdb_ready,
    input  logic                            flush,
    output logic [CDB_W-1:0]                cdb,
    output logic                            cdb_valid
);

    localparam int IDX_W  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int SCAN_W = IDX_W + 1;

    logic [IDX_W-1:0] w_gnt_idx;
    logic             w_gnt_found;
    logic             w_accept;
    logic [CDB_W-1:0] r_cdb;
    logic             r_cdb_valid;

`ifdef CDB_ARB_RR_EN
    logic [IDX_W-1:0]  r_ptr;
    logic [SCAN_W-1:0] w_scan;

    // Scan ptr, ptr+1, ... modulo N_UNITS; the extra scan bit holds ptr+i before the wrap.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_gnt_idx   = '0;
        w_gnt_found = 1'b0;
        w_scan      = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            w_scan = {1'b0, r_ptr} + SCAN_W'(i);
            if (w_scan >= SCAN_W'(N_UNITS)) begin
                w_scan = w_scan - SCAN_W'(N_UNITS);
            end
            if (!w_gnt_found && units_cdb_valid[w_scan[IDX_W-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan[IDX_W-1:0];
            end
        end
    end

    // Pointer moves only on an accepted grant; flush suppresses w_accept so it holds.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_idx == IDX_W'(N_UNITS - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end
`else
    // Walking downward leaves the lowest valid index as the winner.
    always_comb begin
        w_gnt_idx   = '0;
        w_gnt_found = 1'b0;
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            if (units_cdb_valid[i]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IDX_W'(i);
            end
        end
    end
`endif

    // Reset gates the grant combinationally so no word is accepted while nrst is low.
    assign w_accept        = w_gnt_found & ~flush & nrst;
    assign units_cdb_ready = w_accept ? (N_UNITS'(1) << w_gnt_idx) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cdb_valid <= 1'b0;
            r_cdb       <= '0;
        end else begin
            r_cdb_valid <= w_accept;
            r_cdb       <= w_accept ? units_cdb[w_gnt_idx] : '0;
        end
    end

    assign cdb       = r_cdb;
    assign cdb_valid = r_cdb_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected broadcast words, a negedge monitor pops them.
// Expected grant patterns follow CDB_ARB_RR_EN when it is defined, fixed priority otherwise.
module tb_cdb_arbiter;

    localparam int N_UNITS = 3;
    localparam int CDB_W   = 37;

    logic                          clk;
    logic                          nrst;
    logic [N_UNITS-1:0][CDB_W-1:0] units_cdb;
    logic [N_UNITS-1:0]            units_cdb_valid;
    logic [N_UNITS-1:0]            units_cdb_ready;
    logic                          flush;
    logic [CDB_W-1:0]              cdb;
    logic                          cdb_valid;

    logic [CDB_W-1:0] words [N_UNITS];
    logic [CDB_W-1:0] sb [$];
    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(.N_UNITS(N_UNITS), .CDB_W(CDB_W)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .units_cdb       (units_cdb),
        .units_cdb_valid (units_cdb_valid),
        .units_cdb_ready (units_cdb_ready),
        .flush           (flush),
        .cdb             (cdb),
        .cdb_valid       (cdb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid broadcast must match the oldest expected word; idle bus must be zero.
    always @(negedge clk) begin
        if (cdb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("cdb_unexpected_valid", 64'(cdb_valid), 64'd0);
            end else begin
                check("cdb_word", 64'(cdb), 64'(sb.pop_front()));
            end
        end else begin
            check("cdb_idle_zero", 64'(cdb), 64'd0);
        end
    end

    // One cycle: drive at posedge+1, check ready at negedge, queue the expected winner's word.
    task automatic step(input logic [N_UNITS-1:0] v, input logic f, input logic [N_UNITS-1:0] exp_rdy,
                        input string name);
        units_cdb_valid = v;
        flush           = f;
        @(negedge clk);
        check(name, 64'(units_cdb_ready), 64'(exp_rdy));
        for (int i = 0; i < N_UNITS; i++) begin
            if (exp_rdy[i]) sb.push_back(words[i]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        words[0] = 37'h01_0000AAAA;
        words[1] = 37'h0A_00000055;
        words[2] = 37'h13_DEADBEEF;
        for (int i = 0; i < N_UNITS; i++) units_cdb[i] = words[i];
        nrst            = 1'b0;
        flush           = 1'b0;
        units_cdb_valid = 3'b111;

        // Reset held with all units requesting.
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(units_cdb_ready), 64'd0);
        check("reset_cdb_valid", 64'(cdb_valid), 64'd0);
        check("reset_cdb", 64'(cdb), 64'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        // Full contention starting from ptr = 0.
        step(3'b111, 1'b0, 3'b001, "contend_0");
`ifdef CDB_ARB_RR_EN
        step(3'b111, 1'b0, 3'b010, "contend_1");
        step(3'b111, 1'b0, 3'b100, "contend_2");
        step(3'b111, 1'b0, 3'b001, "contend_wrap");
`else
        step(3'b111, 1'b0, 3'b001, "contend_1");
        step(3'b111, 1'b0, 3'b001, "contend_2");
        step(3'b111, 1'b0, 3'b001, "contend_3");
`endif
        step(3'b000, 1'b0, 3'b000, "idle_a");

        // Single requester granted back to back.
        for (int i = 0; i < 4; i++) step(3'b010, 1'b0, 3'b010, "single_mfu");
        step(3'b000, 1'b0, 3'b000, "idle_b");

        // Unit 2 accepted, then flush with unit 0 waiting; unit 0 granted right after.
        step(3'b100, 1'b0, 3'b100, "pre_flush_mmu");
        step(3'b001, 1'b1, 3'b000, "flush_ready");
        step(3'b001, 1'b0, 3'b001, "post_flush_alu");

        // Flush under full contention must not move the pointer (ptr = 1 in round-robin).
        step(3'b111, 1'b1, 3'b000, "flush_contend");
`ifdef CDB_ARB_RR_EN
        step(3'b111, 1'b0, 3'b010, "flush_ptr_hold");
`else
        step(3'b111, 1'b0, 3'b001, "flush_ptr_hold");
`endif
        step(3'b000, 1'b0, 3'b000, "idle_c");

        // Asynchronous reset while a broadcast is on the bus.
        step(3'b010, 1'b0, 3'b010, "pre_reset_mfu");
        check("pre_reset_valid", 64'(cdb_valid), 64'd1);
        units_cdb_valid = 3'b111;
        #2;
        nrst = 1'b0;
        #1;
        check("async_cdb_valid", 64'(cdb_valid), 64'd0);
        check("async_cdb", 64'(cdb), 64'd0);
        check("async_ready", 64'(units_cdb_ready), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        // ptr restarts at 0: unit 0 wins over unit 2.
        step(3'b101, 1'b0, 3'b001, "post_reset_ptr");
        step(3'b000, 1'b0, 3'b000, "idle_d");
        step(3'b000, 1'b0, 3'b000, "idle_e");

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the common data bus (CDB) between the result-producing units (ALU, MFU, MMU return path) and drives one registered broadcast per cycle to every CDB snooper: reservation stations, reorder buffer and operand bypass. It replaces the combinational lowest-index priority select in `core` with a fair, pipelined grant stage. It also flushes in-flight broadcasts on a branch misprediction.

## Interface
- `N_UNITS`, 3: number of requesting units; index 0 = ALU, 1 = MFU, 2 = MMU.
- `CDB_W`, 37: CDB word width, `{rsv_id, data}` = RSV_ID_W + DATA_W.
- `clk`  in  1: single clock; all state on rising edge.
- `nrst`  in  1: asynchronous, active-low reset.
- `units_cdb`  in  N_UNITS×CDB_W: per-unit result word (packed, unit i at `[i]`).
- `units_cdb_valid`  in  N_UNITS: unit i holds a result.
- `units_cdb_ready`  out  N_UNITS: one-hot grant.
  - Unit i's word is accepted on an edge where valid[i] and ready[i] are both 1.
- `flush`  in  1: pred_miss; kills the grant and the registered broadcast.
- `cdb`  out  CDB_W: broadcast word.
- `cdb_valid`  out  1: broadcast valid; high for exactly one cycle per accepted word.

## Operation
- Grant logic is combinational:
  - `units_cdb_ready` is at most one-hot.
  - Bit i may be 1 only if `units_cdb_valid[i]` = 1, `flush` = 0 and `nrst` = 1.
  - Units must not make valid depend on ready.
- Round-robin pointer `ptr` (width clog2(N_UNITS)), reset 0:
  - The grant goes to the first valid unit scanning ptr, ptr+1, … mod N_UNITS.
  - After an accepted grant to unit k, `ptr` ← (k+1) mod N_UNITS. Wraps from N_UNITS−1 to 0.
  - With no grant, or while `flush` is high, `ptr` is unchanged.
- Output register:
  - On each edge, `cdb_valid` ← (a grant occurred) and `flush` = 0.
  - `cdb` ← the granted word, or 0 when there is no grant.
- There is no backpressure on the broadcast. Snoopers sample the bus every cycle it is valid. Sustained throughput is 1 word/cycle.
- A unit holds its word and valid until it sees ready. Valid may drop only after acceptance.
- Flush:
  - `flush` = 1 in cycle t: all ready = 0 in t.
  - `cdb_valid` = 0 in t+1, so a word registered at the edge ending t−1 is still visible during t only.
- Reset (`nrst` low, any time, including mid-broadcast):
  - `cdb` = 0, `cdb_valid` = 0, `ptr` = 0, all ready = 0, asynchronously.
  - The first grant is possible in the first cycle with `nrst` high.
- Invalid words (no grant) never appear on `cdb`. `cdb` is 0 whenever `cdb_valid` = 0.

## Timing
- Latency: request accepted at edge ending cycle t → `cdb`/`cdb_valid` visible in cycle t+1.
- Request-to-grant:
  - 0 cycles when no other unit competes.
  - At most N_UNITS−1 extra cycles under continuous contention when `CDB_ARB_RR_EN` is defined.
- Simultaneous `flush` and requests: the flush wins and no word is accepted; units keep their words.
- A single requester is granted every cycle, back to back.

## Configuration
- `CDB_ARB_RR_EN` defined: round-robin arbitration as above.
- Not defined:
  - Fixed priority, lowest index wins (ALU > MFU > MMU), matching the legacy `core` select.
  - `ptr` is removed; the unused pointer must not be synthesized.
  - All other behaviour (registered output, flush, reset) is identical.

## Test plan
- Reset: hold `nrst` low with all valids high → ready = 000, `cdb_valid` = 0, `cdb` = 0. Release → ready = 001 in the first cycle.
- Single requester: unit 1 valid with word 0x0A_00000055 for 4 cycles → ready = 010 each cycle. `cdb_valid` = 1 with `cdb` = 0x0A_00000055 in cycles 2–5.
- Full contention (RR_EN): all valid continuously with distinct words → grants 001, 010, 100, 001 on consecutive cycles. The CDB shows unit 0, 1, 2, 0 words one cycle later.
- Full contention (no RR_EN): all valid → ready = 001 every cycle. Units 1 and 2 are never granted while unit 0 stays valid.
- Flush: unit 2 accepted in cycle 3, `flush` = 1 in cycle 4 with unit 0 valid:
  - `cdb_valid` = 1 (unit 2 word) in cycle 4.
  - ready = 000 in cycle 4.
  - `cdb_valid` = 0 in cycle 5.
  - Unit 0 is granted in cycle 5 if still valid.
- Async reset mid-stream: drop `nrst` between edges while `cdb_valid` = 1 → `cdb_valid` and `cdb` go to 0 immediately. `ptr` restarts at 0 after release.
